// File: rtl/stopwatch_pkg.sv
// Shared state encoding, default timing constants and a small helper for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } sw_state_t;

  localparam int DEF_TICK_DIV        = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 500_000;

  function automatic logic is_counting(sw_state_t s);
    return (s == RUNNING) || (s == LAP);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop synchronizer -> stability debouncer -> one-cycle press pulse on the 0->1 edge.
// Press appears DEBOUNCE_CYCLES+3 edges after a clean rise; no backpressure.
module button_debouncer
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      // cnt tracks how many consecutive cycles sync2 has disagreed with level
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM with debounced buttons and a one-second prescaler; all outputs registered.
// State changes one cycle after a press pulse; no backpressure.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       hold_count,
  output logic       counter_clear,
  output logic       display_freeze,
  output logic       running,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

  logic ss_evt;
  logic lap_evt;
  logic clr_evt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clock(clock), .reset_n(reset_n), .btn(btn_start_stop), .press(ss_evt)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clock(clock), .reset_n(reset_n), .btn(btn_lap), .press(lap_evt)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clock(clock), .reset_n(reset_n), .btn(btn_clear), .press(clr_evt)
  );

  sw_state_t     state_q;
  sw_state_t     state_d;
  logic [PW-1:0] psc_q;
  logic [PW-1:0] psc_d;
  logic          clr_d;
  logic          hold_q;
  logic          clr_q;
  logic          freeze_q;
  logic          run_q;

  // Only the highest-priority event of a cycle is considered; the rest are dropped.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    if (ss_evt) begin
      case (state_q)
        IDLE:    state_d = RUNNING;
        RUNNING: state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        LAP:     state_d = PAUSED;
        default: state_d = IDLE;
      endcase
    end else if (lap_evt) begin
      case (state_q)
        RUNNING: state_d = LAP;
        LAP:     state_d = RUNNING;
        default: state_d = state_q;
      endcase
    end else if (clr_evt) begin
      case (state_q)
        IDLE: clr_d = 1'b1;
        PAUSED: begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
        default: clr_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    psc_d = psc_q;
    if (clr_d) begin
      psc_d = '0;
    end else if (is_counting(state_q)) begin
      psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + PW'(1);
    end
  end

  // Outputs are computed from next-state values so they line up with the registered state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      psc_q    <= '0;
      hold_q   <= 1'b1;
      clr_q    <= 1'b1;
      freeze_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      psc_q    <= psc_d;
      hold_q   <= ~(is_counting(state_d) && (psc_d == PSC_LAST));
      clr_q    <= clr_d;
      freeze_q <= (state_d == LAP);
      run_q    <= is_counting(state_d);
    end
  end

  assign hold_count     = hold_q;
  assign counter_clear  = clr_q;
  assign display_freeze = freeze_q;
  assign running        = run_q;
  assign state          = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Randomized and directed bench for stopwatch_controller against a behavioural model.
module tb_stopwatch_controller;

  localparam int TD = 10;
  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] btn = 3'b000;  // 0: start_stop, 1: lap, 2: clear
  logic       hold_count;
  logic       counter_clear;
  logic       display_freeze;
  logic       running;
  logic [1:0] state;

  stopwatch_controller #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .btn_start_stop(btn[0]),
    .btn_lap(btn[1]),
    .btn_clear(btn[2]),
    .hold_count(hold_count),
    .counter_clear(counter_clear),
    .display_freeze(display_freeze),
    .running(running),
    .state(state)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transition table indexed [state][event], events 0=start_stop 1=lap 2=clear.
  int ntbl [4][3] = '{'{1, 0, 0}, '{2, 3, 1}, '{1, 2, 0}, '{2, 1, 3}};

  int m_state;
  int m_ticks;  // cycles spent counting since last clear
  int m_cc;
  int m_ev;
  bit m_s1 [3];
  bit m_s2 [3];
  bit m_lvl [3];
  bit m_press [3];
  bit m_hist [3][DB];
  bit all_diff;

  function automatic int m_counting(input int s);
    return int'(s == 1 || s == 3);
  endfunction

  function automatic int m_hold();
    return int'(!(m_counting(m_state) != 0 && (m_ticks % TD) == TD - 1));
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0;
      m_ticks = 0;
      m_cc = 1;
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_press[b] = 0;
        for (int k = 0; k < DB; k++) m_hist[b][k] = 0;
      end
    end else begin
      m_ev = m_press[0] ? 0 : m_press[1] ? 1 : m_press[2] ? 2 : -1;
      m_cc = 0;
      if (m_counting(m_state) != 0) m_ticks++;
      if (m_ev >= 0) begin
        if (m_ev == 2 && (m_state == 0 || m_state == 2)) begin
          m_cc = 1;
          m_ticks = 0;
        end
        m_state = ntbl[m_state][m_ev];
      end
      // A level is accepted once the last DB synchronized samples all disagree with it.
      for (int b = 0; b < 3; b++) begin
        for (int k = DB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = m_s2[b];
        all_diff = 1;
        for (int k = 0; k < DB; k++) if (m_hist[b][k] == m_lvl[b]) all_diff = 0;
        m_press[b] = 0;
        if (all_diff) begin
          m_lvl[b] = !m_lvl[b];
          m_press[b] = m_lvl[b];
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = btn[b];
      end
    end
  end

  // ---------------- per-cycle monitor ----------------
  bit chk_en = 0;
  int cc_cnt = 0;
  int hl_cnt = 0;
  int st_chg = 0;
  int prev_st = 0;

  always @(negedge clock) begin
    if (chk_en) begin
      chk_eq("state", int'(state), m_state);
      chk_eq("running", int'(running), m_counting(m_state));
      chk_eq("display_freeze", int'(display_freeze), int'(m_state == 3));
      chk_eq("counter_clear", int'(counter_clear), m_cc);
      chk_eq("hold_count", int'(hold_count), m_hold());
      if (counter_clear) cc_cnt++;
      if (!hold_count) hl_cnt++;
      if (int'(state) != prev_st) st_chg++;
      prev_st = int'(state);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d expected 0 remaining", 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b1;
    repeat (hold) tick();
    btn[b] = 1'b0;
    repeat (10) tick();
  endtask

  int c0;
  int frac;
  int k;
  int hold_left [3];

  initial begin
    tick();
    chk_en = 1;
    repeat (2) tick();
    chk_eq("rst_counter_clear", int'(counter_clear), 1);
    chk_eq("rst_hold_count", int'(hold_count), 1);
    chk_eq("rst_state", int'(state), 0);
    reset_n = 1'b1;
    tick();
    chk_eq("clear_deassert", int'(counter_clear), 0);
    c0 = hl_cnt;
    repeat (100) tick();
    chk_eq("idle_no_ticks", hl_cnt - c0, 0);
    chk_eq("idle_state", int'(state), 0);

    // Clean start press, then 5 second pulses in 50 cycles.
    press(0, 10);
    chk_eq("start_running", int'(state), 1);
    c0 = hl_cnt;
    repeat (50) tick();
    chk_eq("ticks_in_50", hl_cnt - c0, 5);

    // Bouncy press produces exactly one transition.
    c0 = st_chg;
    btn[0] = 1; tick(); btn[0] = 0; tick(); btn[0] = 1; tick(); btn[0] = 0; tick();
    btn[0] = 1; repeat (10) tick(); btn[0] = 0; repeat (12) tick();
    chk_eq("bounce_one_change", st_chg - c0, 1);
    chk_eq("bounce_paused", int'(state), 2);

    // Paused fraction is preserved: first tick after resume lands TD-frac cycles in.
    repeat (20) tick();
    frac = m_ticks % TD;
    btn[0] = 1'b1;
    k = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (state == 2'd1) k++;
      if (k > 0 && !hold_count) break;
    end
    chk_eq("resume_first_tick", k, TD - frac);
    btn[0] = 1'b0;
    repeat (10) tick();

    // Lap freezes the display while counting continues.
    press(1, 6);
    chk_eq("lap_state", int'(state), 3);
    chk_eq("lap_freeze", int'(display_freeze), 1);
    c0 = hl_cnt;
    repeat (30) tick();
    chk_eq("lap_ticks", hl_cnt - c0, 3);
    press(1, 6);
    chk_eq("unlap_state", int'(state), 1);
    chk_eq("unlap_freeze", int'(display_freeze), 0);

    // Start_stop beats clear when both land together in PAUSED.
    press(0, 6);
    chk_eq("pause_again", int'(state), 2);
    c0 = cc_cnt;
    btn[0] = 1'b1; btn[2] = 1'b1;
    repeat (6) tick();
    btn[0] = 1'b0; btn[2] = 1'b0;
    repeat (10) tick();
    chk_eq("prio_state", int'(state), 1);
    chk_eq("prio_no_clear", cc_cnt - c0, 0);
    press(0, 6);
    c0 = cc_cnt;
    press(2, 6);
    chk_eq("clear_to_idle", int'(state), 0);
    chk_eq("clear_one_pulse", cc_cnt - c0, 1);

    // Randomized buttons with occasional asynchronous resets.
    for (int b = 0; b < 3; b++) hold_left[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold_left[b] == 0) begin
          btn[b] = ($urandom_range(0, 2) == 0);
          hold_left[b] = $urandom_range(1, 12);
        end else begin
          hold_left[b]--;
        end
      end
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
